// File: rtl/pico_ahb_bridge.sv
`default_nettype none
// ============================================================================
// pico_ahb_bridge : picorv32 native memory port to single-transfer AHB-Lite master
// Revision 1.0
// ============================================================================
module pico_ahb_bridge #(
  parameter int TIMEOUT  = 256,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic                mem_instr,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  output logic [31:0]         HADDR,
  output logic [1:0]          HTRANS,
  output logic [2:0]          HSIZE,
  output logic                HWRITE,
  output logic [2:0]          HBURST,
  output logic                HMASTLOCK,
  output logic [3:0]          HPROT,
  output logic [31:0]         HWDATA,
  input  logic [31:0]         HRDATA,
  input  logic                HREADY,
  input  logic                HRESP,
  output logic                bus_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_haddr;
  logic [2:0]            r_hsize;
  logic                  r_hwrite;
  logic [3:0]            r_hprot;
  logic [31:0]           r_wdata;
  logic [31:0]           r_hwdata;
  logic [31:0]           r_rdata;
  logic [WAIT_W-1:0]     r_wait;
  logic [ERRCNT_W-1:0]   r_err_count;
  logic                  w_legal;
  logic [2:0]            w_size;
  logic [1:0]            w_lane;
  logic                  w_timeout_hit;
  logic                  w_unused_addr;

  // Byte lanes come from the strobe, so the low address bits are not needed.
  assign w_unused_addr = ^mem_addr[1:0];

  always_comb begin
    w_legal = 1'b1;
    w_size  = 3'b010;
    w_lane  = 2'b00;
    case (mem_wstrb)
      4'b0000, 4'b1111: ;
      4'b0011: w_size = 3'b001;
      4'b1100: begin w_size = 3'b001; w_lane = 2'b10; end
      4'b0001: w_size = 3'b000;
      4'b0010: begin w_size = 3'b000; w_lane = 2'b01; end
      4'b0100: begin w_size = 3'b000; w_lane = 2'b10; end
      4'b1000: begin w_size = 3'b000; w_lane = 2'b11; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait == c_WAIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (mem_valid) w_next = w_legal ? S_ADDR : S_ERR;
      S_ADDR: if (HREADY) w_next = S_DATA;
      S_DATA: begin
        if (HREADY)                      w_next = HRESP ? S_ERR : S_DONE;
        else if (!HRESP && w_timeout_hit) w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_haddr     <= '0;
      r_hsize     <= '0;
      r_hwrite    <= 1'b0;
      r_hprot     <= '0;
      r_wdata     <= '0;
      r_hwdata    <= '0;
      r_rdata     <= '0;
      r_wait      <= '0;
      r_err_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (mem_valid && w_legal) begin
          r_haddr  <= {mem_addr[31:2], w_lane};
          r_hsize  <= w_size;
          r_hwrite <= |mem_wstrb;
          r_hprot  <= {3'b001, ~mem_instr};
          r_wdata  <= mem_wdata;
        end
        S_ADDR: if (HREADY) begin
          r_hwdata <= r_wdata;
          r_wait   <= '0;
        end
        S_DATA: begin
          if (HREADY && !HRESP) r_rdata <= r_hwrite ? 32'h0 : HRDATA;
          // The first cycle of a two-cycle error response is not a wait state.
          else if (!HREADY && !HRESP) r_wait <= r_wait + 1'b1;
        end
        S_ERR: if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_ready = (r_state == S_DONE) || (r_state == S_ERR);
  assign mem_rdata = (r_state == S_DONE) ? r_rdata : 32'h0;
  assign bus_err   = (r_state == S_ERR);
  assign err_count = r_err_count;
  assign HTRANS    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = r_haddr;
  assign HSIZE     = r_hsize;
  assign HWRITE    = r_hwrite;
  assign HPROT     = r_hprot;
  assign HWDATA    = r_hwdata;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;

endmodule
`default_nettype wire
